// File: rtl/port_parse.sv
// port_parse: ingress header parser. Captures DA/SA from one port's byte stream and emits one
// {PORT_ID, SA, DA} word per packet. Optional macro PARSE_HOLD_EN: emit only on good EOP.
module port_parse #(
  parameter int PORT_ID = 0,
  parameter int PORT_W  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_srdy,
  output logic                 rx_drdy,
  input  logic [1:0]           rx_code,
  input  logic [7:0]           rx_data,
  output logic                 ppi_srdy,
  input  logic                 ppi_drdy,
  output logic [96+PORT_W-1:0] ppi_data,
  output logic [7:0]           drop_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, WAIT, BODY} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          bc_reg, bc_next;
  logic [95:0]         hdr_reg, hdr_next;
  logic                done_reg, done_next;
  logic                rdy_en_reg;
  logic                srdy_reg, srdy_next;
  logic [96+PORT_W-1:0] data_reg, data_next;
  logic [7:0]          drop_reg, drop_next;

  logic        accept, is_sop, is_eop, out_free, load, drop_evt;
  logic [95:0] hdr_shift;

  assign rx_drdy   = rdy_en_reg && (state_reg != WAIT);
  assign accept    = rx_srdy && rx_drdy;
  assign is_sop    = (rx_code == 2'b01);
  assign is_eop    = rx_code[1];
  assign out_free  = !srdy_reg || ppi_drdy;
  assign hdr_shift = {hdr_reg[87:0], rx_data};

  assign ppi_srdy = srdy_reg;
  assign ppi_data = data_reg;
  assign drop_cnt = drop_reg;

  // done_reg remembers that the packet already ended, so WAIT returns to IDLE instead of BODY
  always_comb begin
    state_next = state_reg;
    bc_next    = bc_reg;
    hdr_next   = hdr_reg;
    done_next  = done_reg;
    load       = 1'b0;
    drop_evt   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept && is_sop) begin
          hdr_next   = hdr_shift;
          bc_next    = 4'd1;
          state_next = HDR;
        end
      end
      HDR: begin
        if (accept) begin
          hdr_next = hdr_shift;
          if (is_sop) begin
            drop_evt = 1'b1;
            bc_next  = 4'd1;
          end else if (bc_reg == 4'd11) begin
`ifdef PARSE_HOLD_EN
            if (!is_eop) begin
              state_next = BODY;
            end else if (rx_code[0]) begin
              drop_evt   = 1'b1;
              state_next = IDLE;
            end else if (out_free) begin
              load       = 1'b1;
              state_next = IDLE;
            end else begin
              done_next  = 1'b1;
              state_next = WAIT;
            end
`else
            done_next = is_eop;
            if (out_free) begin
              load       = 1'b1;
              state_next = is_eop ? IDLE : BODY;
            end else begin
              state_next = WAIT;
            end
`endif
          end else if (is_eop) begin
            drop_evt   = 1'b1;
            state_next = IDLE;
          end else begin
            bc_next = bc_reg + 4'd1;
          end
        end
      end
      WAIT: begin
        if (out_free) begin
          load       = 1'b1;
          state_next = done_reg ? IDLE : BODY;
        end
      end
      BODY: begin
        if (accept) begin
          if (is_sop) begin
            hdr_next   = hdr_shift;
            bc_next    = 4'd1;
            state_next = HDR;
`ifdef PARSE_HOLD_EN
            drop_evt   = 1'b1;  // held header never reached a good EOP
`endif
          end else if (is_eop) begin
`ifdef PARSE_HOLD_EN
            if (rx_code[0]) begin
              drop_evt   = 1'b1;
              state_next = IDLE;
            end else if (out_free) begin
              load       = 1'b1;
              state_next = IDLE;
            end else begin
              done_next  = 1'b1;
              state_next = WAIT;
            end
`else
            state_next = IDLE;
`endif
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // capture reg holds {DA, SA}; output word orders it as {PORT_ID, SA, DA}
    data_next = load ? {PORT_W'(PORT_ID), hdr_next[47:0], hdr_next[95:48]} : data_reg;
    srdy_next = load || (srdy_reg && !ppi_drdy);
    drop_next = (drop_evt && (drop_reg != 8'hFF)) ? drop_reg + 8'd1 : drop_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      bc_reg     <= 4'd0;
      hdr_reg    <= 96'd0;
      done_reg   <= 1'b0;
      rdy_en_reg <= 1'b0;
      srdy_reg   <= 1'b0;
      data_reg   <= '0;
      drop_reg   <= 8'd0;
    end else begin
      state_reg  <= state_next;
      bc_reg     <= bc_next;
      hdr_reg    <= hdr_next;
      done_reg   <= done_next;
      rdy_en_reg <= 1'b1;
      srdy_reg   <= srdy_next;
      data_reg   <= data_next;
      drop_reg   <= drop_next;
    end
  end

endmodule

// File: tb/tb_port_parse.sv
// Directed bench for port_parse (PORT_ID=2, PORT_W=2); expectations adapt to PARSE_HOLD_EN.
module tb_port_parse;
  localparam int DW = 98;
`ifdef PARSE_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx_srdy = 1'b0;
  logic          rx_drdy;
  logic [1:0]    rx_code = 2'b00;
  logic [7:0]    rx_data = 8'h00;
  logic          ppi_srdy;
  logic          ppi_drdy = 1'b0;
  logic [DW-1:0] ppi_data;
  logic [7:0]    drop_cnt;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  bit abort = 1'b0;
  logic [DW-1:0] words[$];

  port_parse #(.PORT_ID(2), .PORT_W(2)) dut (
    .clk(clk), .reset(reset),
    .rx_srdy(rx_srdy), .rx_drdy(rx_drdy), .rx_code(rx_code), .rx_data(rx_data),
    .ppi_srdy(ppi_srdy), .ppi_drdy(ppi_drdy), .ppi_data(ppi_data), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // sample handshakes 1 ns before each rising edge
  always begin
    @(negedge clk);
    #4;
    if (ppi_srdy && ppi_drdy) words.push_back(ppi_data);
    if (rx_srdy && rx_drdy) acc_cnt++;
  end

  task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [7:0] pkt_byte(input int i, input logic [47:0] da, input logic [47:0] sa);
    if (i < 6) return da[47-8*i -: 8];
    else if (i < 12) return sa[47-8*(i-6) -: 8];
    else return 8'(i);
  endfunction

  function automatic logic [1:0] pkt_code(input int i, input int len, input logic [1:0] last);
    if (i == 0) return 2'b01;
    else if (i == len - 1) return last;
    else return 2'b00;
  endfunction

  function automatic logic [DW-1:0] mkword(input logic [47:0] da, input logic [47:0] sa);
    return {2'd2, sa, da};
  endfunction

  // called at a falling edge; returns at the falling edge after the byte is taken
  task automatic send_byte(input logic [1:0] code, input logic [7:0] data);
    int n = 0;
    rx_srdy = 1'b1;
    rx_code = code;
    rx_data = data;
    while (!rx_drdy && !abort && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!abort && n >= 300) check_value("rx_accept_timeout", n, 0);
    if (!abort) @(negedge clk);
    rx_srdy = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [47:0] da, input logic [47:0] sa,
                          input logic [1:0] last);
    for (int i = 0; i < len; i++) send_byte(pkt_code(i, len, last), pkt_byte(i, da, sa));
  endtask

  task automatic expect_word(input string tag, input logic [DW-1:0] exp);
    repeat (2) @(negedge clk);
    check_value({tag, "_cnt"}, words.size(), 1);
    if (words.size() > 0) check_value(tag, words.pop_front(), exp);
    words.delete();
  endtask

  task automatic wait_stall(input string tag);
    int n = 0;
    while (rx_drdy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_value(tag, rx_drdy, 0);
  endtask

  initial begin
    int acc0;
    // reset state
    repeat (2) @(negedge clk);
    check_value("rst_rx_drdy", rx_drdy, 0);
    check_value("rst_srdy", ppi_srdy, 0);
    check_value("rst_data", ppi_data, 0);
    check_value("rst_drop", drop_cnt, 0);
    reset = 1'b1;
    @(negedge clk);
    check_value("rel_rx_drdy", rx_drdy, 1);

    // 64B packet, consumer always ready
    ppi_drdy = 1'b1;
    for (int i = 0; i < 64; i++) begin
      send_byte(pkt_code(i, 64, 2'b10), pkt_byte(i, 48'h010203040506, 48'h0A0B0C0D0E0F));
      if (i == 10) check_value("t64_srdy_b11", ppi_srdy, 0);
      if (i == 11) check_value("t64_srdy_b12", ppi_srdy, !HOLD);
      if (i == 63) check_value("t64_srdy_eop", ppi_srdy, HOLD);
    end
    expect_word("t64_word", mkword(48'h010203040506, 48'h0A0B0C0D0E0F));

    // back-to-back 20B packets with consumer stalled
    ppi_drdy = 1'b0;
    acc0 = acc_cnt;
    fork
      begin
        send_pkt(20, 48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 2'b10);
        send_pkt(20, 48'hC1C2C3C4C5C6, 48'hD1D2D3D4D5D6, 2'b10);
      end
      begin
        wait_stall("b2b_stall");
        check_value("b2b_hold_data", ppi_data, mkword(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6));
        check_value("b2b_hold_srdy", ppi_srdy, 1);
        repeat (3) @(negedge clk);
        check_value("b2b_stable_data", ppi_data, mkword(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6));
        check_value("b2b_still_stall", rx_drdy, 0);
        ppi_drdy = 1'b1;
        @(negedge clk);
        check_value("b2b_second_data", ppi_data, mkword(48'hC1C2C3C4C5C6, 48'hD1D2D3D4D5D6));
        check_value("b2b_second_srdy", ppi_srdy, 1);
        check_value("b2b_rx_resume", rx_drdy, 1);
      end
    join
    repeat (2) @(negedge clk);
    check_value("b2b_word_cnt", words.size(), 2);
    if (words.size() == 2) begin
      check_value("b2b_word0", words.pop_front(), mkword(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6));
      check_value("b2b_word1", words.pop_front(), mkword(48'hC1C2C3C4C5C6, 48'hD1D2D3D4D5D6));
    end
    words.delete();
    check_value("b2b_bytes", acc_cnt - acc0, 40);

    // runts and saturation
    send_pkt(8, 48'h111111111111, 48'h222222222222, 2'b10);
    repeat (2) @(negedge clk);
    check_value("runt8_no_word", words.size(), 0);
    check_value("runt8_drop", drop_cnt, 1);
    for (int i = 2; i <= 300; i++) begin
      send_pkt(2, 48'h0, 48'h0, 2'b10);
      if (i == 254) check_value("runt_drop_254", drop_cnt, 254);
    end
    check_value("runt_drop_sat", drop_cnt, 255);
    check_value("runt_no_word", words.size(), 0);

    // reset mid-header
    send_byte(2'b01, 8'h55);
    for (int i = 0; i < 3; i++) send_byte(2'b00, 8'h66);
    reset = 1'b0;
    @(negedge clk);
    check_value("rsthdr_srdy", ppi_srdy, 0);
    check_value("rsthdr_drop", drop_cnt, 0);
    check_value("rsthdr_rx_drdy", rx_drdy, 0);
    reset = 1'b1;
    @(negedge clk);

    // SOP as 5th header byte aborts and restarts capture
    send_byte(2'b01, 8'h77);
    for (int i = 0; i < 3; i++) send_byte(2'b00, 8'h88);
    send_pkt(20, 48'h313233343536, 48'h414243444546, 2'b10);
    check_value("abort_drop", drop_cnt, 1);
    expect_word("abort_word", mkword(48'h313233343536, 48'h414243444546));

    // 32B packet ending in error, then a good one
    send_pkt(32, 48'h515253545556, 48'h616263646566, 2'b11);
    repeat (2) @(negedge clk);
    check_value("err_word_cnt", words.size(), !HOLD);
    if (words.size() > 0) check_value("err_word", words.pop_front(),
                                      mkword(48'h515253545556, 48'h616263646566));
    words.delete();
    check_value("err_drop", drop_cnt, HOLD ? 2 : 1);
    send_pkt(32, 48'h717273747576, 48'h818283848586, 2'b10);
    check_value("good32_srdy_eop", ppi_srdy, HOLD);
    expect_word("good32_word", mkword(48'h717273747576, 48'h818283848586));

    // reset while stalled in WAIT
    ppi_drdy = 1'b0;
    send_pkt(20, 48'h919293949596, 48'h9A9B9C9D9E9F, 2'b10);
    fork
      send_pkt(20, 48'hE1E2E3E4E5E6, 48'hF1F2F3F4F5F6, 2'b10);
      begin
        wait_stall("rstwait_stall");
        reset = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        check_value("rstwait_srdy", ppi_srdy, 0);
        check_value("rstwait_drop", drop_cnt, 0);
        check_value("rstwait_data", ppi_data, 0);
      end
    join
    abort = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_value("rstwait_no_word", words.size(), 0);
    ppi_drdy = 1'b1;
    send_pkt(20, 48'h123456789ABC, 48'hDEF012345678, 2'b10);
    expect_word("post_rst_word", mkword(48'h123456789ABC, 48'hDEF012345678));
    check_value("post_rst_drop", drop_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
